// File: rtl/vs_stream_ctrl.sv
// VS10xx SPI streaming controller: hardware reset pulse, SCI init writes, DREQ-gated SDI bursts.
// Define VS_VOLUME_UPDATE_EN to re-send SCI_VOL between bursts when the volume input changes.
module vs_stream_ctrl #(
   parameter int unsigned CLK_DIV      = 10,
   parameter int unsigned RESET_CYCLES = 5000,
   parameter int unsigned WORD_W       = 16,
   parameter int unsigned ADDR_W       = 15,
   parameter logic [15:0] MODE_VAL     = 16'h0804
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dreq,
   input  logic              play,
   input  logic              loop,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic [15:0]       volume,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              xrst,
   output logic              xcs,
   output logic              xdcs,
   output logic              sck,
   output logic              si,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DivW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned RstW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int unsigned BurstWords = 256 / WORD_W;
   localparam int unsigned BurstW     = $clog2(BurstWords + 1);

   typedef enum logic [3:0] {
      StRstHold, StCmdWait, StCmdShift, StIdle, StFetch, StDataShift, StDone
`ifdef VS_VOLUME_UPDATE_EN
      , StVolWait, StVolShift
`endif
   } state_e;

   state_e            state_q;
   logic [DivW-1:0]   div_cnt_q;
   logic [RstW-1:0]   rst_cnt_q;
   logic              dreq_s1_q, dreq_s2_q;
   logic              cmd_idx_q;
   logic              phase_q;
   logic [5:0]        bit_cnt_q;
   logic [31:0]       sh_q;
   logic [BurstW-1:0] words_left_q;
   logic [1:0]        fetch_cnt_q;
   logic              tick;
   logic              sci_shift;
`ifdef VS_VOLUME_UPDATE_EN
   logic [15:0]       vol_q;
   logic [15:0]       vol_cur_q;
`endif

   assign tick = (div_cnt_q == DivW'(CLK_DIV - 1));

`ifdef VS_VOLUME_UPDATE_EN
   assign sci_shift = (state_q == StCmdShift) || (state_q == StVolShift);
`else
   assign sci_shift = (state_q == StCmdShift);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StRstHold;
         div_cnt_q    <= '0;
         rst_cnt_q    <= '0;
         dreq_s1_q    <= 1'b0;
         dreq_s2_q    <= 1'b0;
         cmd_idx_q    <= 1'b0;
         phase_q      <= 1'b0;
         bit_cnt_q    <= '0;
         sh_q         <= '0;
         words_left_q <= '0;
         fetch_cnt_q  <= '0;
         mem_addr     <= '0;
         xrst         <= 1'b0;
         xcs          <= 1'b1;
         xdcs         <= 1'b1;
         sck          <= 1'b0;
         si           <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
`ifdef VS_VOLUME_UPDATE_EN
         vol_q        <= '0;
         vol_cur_q    <= '0;
`endif
      end else begin
         dreq_s1_q <= dreq;
         dreq_s2_q <= dreq_s1_q;
         div_cnt_q <= tick ? '0 : div_cnt_q + DivW'(1);

         // Fetch runs on raw clocks: one clk for the address to reach memory, one to capture.
         if (state_q == StFetch && fetch_cnt_q != 2'd2) begin
            fetch_cnt_q <= fetch_cnt_q + 2'd1;
            if (fetch_cnt_q == 2'd1) sh_q <= 32'(mem_rdata) << (32 - WORD_W);
         end else if (tick) begin
            if (sci_shift) begin
               if (phase_q) begin
                  sck       <= 1'b1;
                  sh_q      <= sh_q << 1;
                  bit_cnt_q <= bit_cnt_q + 6'd1;
                  phase_q   <= 1'b0;
               end else if (bit_cnt_q == 6'd32) begin
                  xcs <= 1'b1;
                  sck <= 1'b0;
                  si  <= 1'b0;
                  if (state_q == StCmdShift && !cmd_idx_q) begin
                     cmd_idx_q <= 1'b1;
                     state_q   <= StCmdWait;
                  end else begin
                     if (state_q == StCmdShift) mem_addr <= start_addr;
                     state_q <= StIdle;
                  end
               end else begin
                  xcs     <= 1'b0;
                  sck     <= 1'b0;
                  si      <= sh_q[31];
                  phase_q <= 1'b1;
               end
            end else begin
               case (state_q)
                  StRstHold: begin
                     if (rst_cnt_q == RstW'(RESET_CYCLES - 1)) begin
                        xrst    <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StCmdWait;
                     end else begin
                        rst_cnt_q <= rst_cnt_q + RstW'(1);
                     end
                  end
                  StCmdWait: begin
                     if (dreq_s2_q) begin
                        sh_q      <= cmd_idx_q ? {8'h02, 8'h0B, volume} : {8'h02, 8'h00, MODE_VAL};
                        bit_cnt_q <= '0;
                        phase_q   <= 1'b0;
                        state_q   <= StCmdShift;
`ifdef VS_VOLUME_UPDATE_EN
                        if (cmd_idx_q) begin
                           vol_q     <= volume;
                           vol_cur_q <= volume;
                        end
`endif
                     end
                  end
                  StIdle: begin
                     sck <= 1'b0;
`ifdef VS_VOLUME_UPDATE_EN
                     if (words_left_q == '0 && vol_q != vol_cur_q) begin
                        state_q <= StVolWait;
                     end else
`endif
                     // A paused burst resumes without waiting for dreq again.
                     if (play && (words_left_q != '0 || dreq_s2_q)) begin
                        if (words_left_q == '0) words_left_q <= BurstW'(BurstWords);
                        fetch_cnt_q <= '0;
                        state_q     <= StFetch;
                     end
                  end
                  StFetch: begin
                     xdcs      <= 1'b0;
                     sck       <= 1'b0;
                     si        <= sh_q[31];
                     phase_q   <= 1'b1;
                     bit_cnt_q <= '0;
                     state_q   <= StDataShift;
                  end
                  StDataShift: begin
                     if (phase_q) begin
                        sck       <= 1'b1;
                        sh_q      <= sh_q << 1;
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        phase_q   <= 1'b0;
                     end else if (bit_cnt_q == 6'(WORD_W)) begin
                        sck          <= 1'b0;
                        words_left_q <= words_left_q - BurstW'(1);
`ifdef VS_VOLUME_UPDATE_EN
                        vol_q        <= volume;
`endif
                        if (mem_addr == end_addr && !loop) begin
                           xdcs    <= 1'b1;
                           si      <= 1'b0;
                           busy    <= 1'b0;
                           done    <= 1'b1;
                           state_q <= StDone;
                        end else begin
                           mem_addr    <= (mem_addr == end_addr) ? start_addr
                                                                 : mem_addr + ADDR_W'(1);
                           fetch_cnt_q <= '0;
                           if (words_left_q == BurstW'(1) || !play) begin
                              xdcs    <= 1'b1;
                              state_q <= StIdle;
                           end else begin
                              state_q <= StFetch;
                           end
                        end
                     end else begin
                        sck     <= 1'b0;
                        si      <= sh_q[31];
                        phase_q <= 1'b1;
                     end
                  end
`ifdef VS_VOLUME_UPDATE_EN
                  StVolWait: begin
                     if (dreq_s2_q) begin
                        sh_q      <= {8'h02, 8'h0B, vol_q};
                        vol_cur_q <= vol_q;
                        bit_cnt_q <= '0;
                        phase_q   <= 1'b0;
                        state_q   <= StVolShift;
                     end
                  end
`endif
                  StDone: begin
                     sck <= 1'b0;
                  end
                  default: state_q <= StRstHold;
               endcase
            end
         end
      end
   end

endmodule

// File: doc/vs_stream_ctrl.md
# vs_stream_ctrl

Parametrised SPI streaming controller for a VS10xx-class MP3 decoder. Generates the hardware reset pulse, issues the SCI initialisation writes (mode, volume), then streams audio words from a synchronous ROM/BRAM over SDI in DREQ-gated 32-byte bursts. Adds play/pause, loop and end-of-track detection, runtime volume updates, configurable SPI clock divider and word width. Sits between the audio block memory and the decoder pins at top level.

## Interface
- CLK_DIV, 10: clk cycles per SPI tick (half SCK period), ≥1
- RESET_CYCLES, 5000: ticks xrst held low after reset
- WORD_W, 16: memory word width; 8, 16 or 32
- ADDR_W, 15: memory address width
- MODE_VAL, 16'h0804: value written to SCI_MODE (reg 0x00)
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- dreq  in  1  decoder data request (asynchronous; 2-flop synchronised internally)
- play  in  1  1 = stream, 0 = pause
- loop  in  1  1 = wrap to start_addr at end of track
- start_addr  in  ADDR_W  first word of track
- end_addr  in  ADDR_W  last word of track (inclusive)
- volume  in  16  SCI_VOL value {left, right} attenuation
- mem_rdata  in  WORD_W  memory read data, valid 1 clk after mem_addr
- mem_addr  out  ADDR_W  memory read address
- xrst  out  1  decoder reset, active low
- xcs  out  1  SCI chip select, active low
- xdcs  out  1  SDI chip select, active low
- sck  out  1  SPI clock
- si  out  1  SPI data, MSB first
- busy  out  1  high from end of reset pulse until DONE
- done  out  1  high in DONE state

## Operation
- Reset values: xrst=0, xcs=1, xdcs=1, sck=0, si=0, mem_addr=0, busy=0, done=0; all counters 0; state RST_HOLD.
- Tick = one clk cycle in every CLK_DIV; all state/pin updates except memory fetch occur on ticks.
- Bit transfer = 2 ticks: tick A sck←0, si←bit; tick B sck←1 (decoder samples on rising edge).
- States: RST_HOLD → (RESET_CYCLES ticks) xrst←1 → CMD_WAIT → CMD_SHIFT → (second command) CMD_WAIT → CMD_SHIFT → IDLE → FETCH → DATA_SHIFT → … → DONE; VOL_WAIT/VOL_SHIFT when enabled.
- SCI write frame: 32 bits {8'h02, reg[7:0], value[15:0]}. Command 0: reg 0x00, MODE_VAL. Command 1: reg 0x0B, volume sampled at frame start.
- CMD_WAIT: xcs=1, sck=0 for ≥1 tick; leaves only when synchronised dreq=1. xcs←0 on first tick A, ←1 one tick after 32nd tick B.
- IDLE: mem_addr←start_addr on entry from init; if play=1 and dreq=1 start burst.
- Burst: 256/WORD_W words (32 bytes); dreq checked only at burst start, never mid-burst.
- FETCH: present mem_addr, capture mem_rdata next clk into shift register; DATA_SHIFT shifts WORD_W bits with xdcs=0.
- After each word: if mem_addr==end_addr: loop=1 → mem_addr←start_addr, continue; loop=0 → xdcs←1, DONE. Else mem_addr+1 (wraps modulo 2^ADDR_W; no error).
- Pause: play sampled at word boundary; play=0 → xdcs←1, go IDLE keeping mem_addr and remaining burst count; resume continues same burst without re-checking dreq.
- DONE: sticky until rst_n; outputs idle (xcs=xdcs=1, sck=0).
- end_addr<start_addr: streams until wrap reaches end_addr (modulo behaviour).
- rst_n low at any point (mid-frame included): next clk all outputs to reset values; partial frame abandoned.

## Timing
- Memory latency 1 clk; fetch overlaps no shifting (1 extra clk + alignment to next tick per word).
- Word time = 2·WORD_W ticks + fetch; xdcs held low across consecutive words of a burst.
- dreq synchroniser adds 2 clk latency; dreq fall mid-burst ignored.
- SCK frequency = f_clk / (2·CLK_DIV).

## Configuration
- VS_VOLUME_UPDATE_EN defined: volume input registered each word boundary; on change, at next burst boundary (xdcs=1) controller enters VOL_WAIT (wait dreq) and VOL_SHIFT (SCI write reg 0x0B, new value), then returns to IDLE/burst. Simultaneous change and end-of-track: DONE wins, no write.
- Not defined: volume sampled only for init command 1; VOL states absent; later changes ignored.

## Test plan
- Reset: rst_n low 3 clk → all outputs at reset values; xrst rises after exactly RESET_CYCLES·CLK_DIV clk, busy rises same clk.
- Init: dreq=1, volume=16'h2020 → SI captures 32'h02000804 then 32'h020B2020 on sck rising, xcs high between frames.
- Stream: WORD_W=16, memory[i]=i, start=0, end=31, dreq=1 → 32 words MSB-first, xdcs low 16 words, high, then next burst; done after word 31.
- Stall: drop dreq after burst 1 start → burst 1 completes 16 words, burst 2 waits until dreq high.
- Loop/pause: loop=1, end=3 → addresses 0,1,2,3,0,…; play=0 at word 2 → xdcs high, resume sends word 3 next.
- Abort/volume: rst_n low mid-frame → outputs reset next clk; with VS_VOLUME_UPDATE_EN, volume 0→16'h4040 → SCI frame 32'h020B4040 between bursts.
